// File: rtl/calc_pkg.sv
// Shared calculator definitions: command codes, keypad FSM states and the 4x4 keymap.
// Used by keypad_cmd_encoder and Calculadora_Top.
package calc_pkg;

    localparam logic [3:0] CMD_ADD  = 4'hA;
    localparam logic [3:0] CMD_SUB  = 4'hB;
    localparam logic [3:0] CMD_MUL  = 4'hC;
    localparam logic [3:0] CMD_BKSP = 4'hD;
    localparam logic [3:0] CMD_EQ   = 4'hE;
    localparam logic [3:0] CMD_CLR  = 4'hF;

    typedef enum logic [1:0] {
        SCAN        = 2'd0,
        DEB_PRESS   = 2'd1,
        HOLD        = 2'd2,
        DEB_RELEASE = 2'd3
    } kp_state_e;

    // Physical layout: r0 = 1 2 3 +, r1 = 4 5 6 -, r2 = 7 8 9 *, r3 = C 0 = <-
    function automatic logic [3:0] keymap(input logic [1:0] r, input logic [1:0] c);
        logic [3:0] code;
        code = 4'h0;
        case ({r, c})
            4'b00_00: code = 4'h1;
            4'b00_01: code = 4'h2;
            4'b00_10: code = 4'h3;
            4'b00_11: code = CMD_ADD;
            4'b01_00: code = 4'h4;
            4'b01_01: code = 4'h5;
            4'b01_10: code = 4'h6;
            4'b01_11: code = CMD_SUB;
            4'b10_00: code = 4'h7;
            4'b10_01: code = 4'h8;
            4'b10_10: code = 4'h9;
            4'b10_11: code = CMD_MUL;
            4'b11_00: code = CMD_CLR;
            4'b11_01: code = 4'h0;
            4'b11_10: code = CMD_EQ;
            4'b11_11: code = CMD_BKSP;
            default:  code = 4'h0;
        endcase
        return code;
    endfunction

    // True when exactly one active-low row line is asserted.
    function automatic logic single_low(input logic [3:0] rows);
        logic result;
        result = 1'b0;
        case (rows)
            4'b1110, 4'b1101, 4'b1011, 4'b0111: result = 1'b1;
            default:                            result = 1'b0;
        endcase
        return result;
    endfunction

    function automatic logic [1:0] low_index(input logic [3:0] rows);
        logic [1:0] idx;
        idx = 2'd0;
        case (rows)
            4'b1101: idx = 2'd1;
            4'b1011: idx = 2'd2;
            4'b0111: idx = 2'd3;
            default: idx = 2'd0;
        endcase
        return idx;
    endfunction

    function automatic logic [3:0] low_pattern(input logic [1:0] idx);
        return ~(4'b0001 << idx);
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous level inputs, reset to a configurable idle value.
module sync_2ff #(
    parameter int               WIDTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/keypad_cmd_encoder.sv
// Scans a 4x4 active-low keypad, debounces press and release, and emits one
// calculator command code per accepted key (no auto-repeat).
module keypad_cmd_encoder
    import calc_pkg::*;
#(
    parameter int SCAN_DIV     = 1000,
    parameter int DEBOUNCE_CNT = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] row,
    output logic [3:0] col,
    output logic [3:0] cmd,
    output logic       cmd_valid
);

    localparam int TICK_W = $clog2(SCAN_DIV);
    localparam int DEB_W  = $clog2(DEBOUNCE_CNT + 1);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(SCAN_DIV - 1);
    localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE_CNT - 1);
    localparam logic [DEB_W-1:0]  DEB_ONE   = DEB_W'(1);

    logic [3:0]        row_s;
    logic [TICK_W-1:0] tick_cnt_q, tick_cnt_d;
    logic              tick;

    kp_state_e         state_q, state_d;
    logic [1:0]        col_idx_q, col_idx_d;
    logic [1:0]        key_row_q, key_row_d;
    logic [DEB_W-1:0]  deb_cnt_q, deb_cnt_d;
    logic [3:0]        cmd_q, cmd_d;
    logic              cmd_valid_q, cmd_valid_d;

    sync_2ff #(
        .WIDTH     (4),
        .RESET_VAL (4'b1111)
    ) u_row_sync (
        .clock (clock),
        .reset (reset),
        .d     (row),
        .q     (row_s)
    );

    assign tick       = (tick_cnt_q == TICK_LAST);
    assign tick_cnt_d = tick ? '0 : tick_cnt_q + TICK_W'(1);

    always_comb begin
        state_d     = state_q;
        col_idx_d   = col_idx_q;
        key_row_d   = key_row_q;
        deb_cnt_d   = deb_cnt_q;
        cmd_d       = cmd_q;
        cmd_valid_d = 1'b0;

        if (tick) begin
            case (state_q)
                SCAN: begin
                    // Ghosted or multi-key patterns are skipped rather than guessed at.
                    if (single_low(row_s)) begin
                        key_row_d = low_index(row_s);
                        deb_cnt_d = DEB_ONE;
                        state_d   = DEB_PRESS;
                    end else begin
                        col_idx_d = col_idx_q + 2'd1;
                    end
                end

                DEB_PRESS: begin
                    if (row_s == low_pattern(key_row_q)) begin
                        if (deb_cnt_q == DEB_LAST) begin
                            cmd_d       = keymap(key_row_q, col_idx_q);
                            cmd_valid_d = 1'b1;
                            deb_cnt_d   = '0;
                            state_d     = HOLD;
                        end else begin
                            deb_cnt_d = deb_cnt_q + DEB_ONE;
                        end
                    end else begin
                        deb_cnt_d = '0;
                        col_idx_d = col_idx_q + 2'd1;
                        state_d   = SCAN;
                    end
                end

                HOLD: begin
                    if (row_s == 4'b1111) begin
                        deb_cnt_d = DEB_ONE;
                        state_d   = DEB_RELEASE;
                    end
                end

                DEB_RELEASE: begin
                    if (row_s == 4'b1111) begin
                        if (deb_cnt_q == DEB_LAST) begin
                            deb_cnt_d = '0;
                            col_idx_d = 2'd0;
                            state_d   = SCAN;
                        end else begin
                            deb_cnt_d = deb_cnt_q + DEB_ONE;
                        end
                    end else begin
                        deb_cnt_d = '0;
                        state_d   = HOLD;
                    end
                end

                default: begin
                    deb_cnt_d = '0;
                    col_idx_d = 2'd0;
                    state_d   = SCAN;
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            tick_cnt_q  <= '0;
            state_q     <= SCAN;
            col_idx_q   <= 2'd0;
            key_row_q   <= 2'd0;
            deb_cnt_q   <= '0;
            cmd_q       <= 4'h0;
            cmd_valid_q <= 1'b0;
        end else begin
            tick_cnt_q  <= tick_cnt_d;
            state_q     <= state_d;
            col_idx_q   <= col_idx_d;
            key_row_q   <= key_row_d;
            deb_cnt_q   <= deb_cnt_d;
            cmd_q       <= cmd_d;
            cmd_valid_q <= cmd_valid_d;
        end
    end

    assign col       = ~(4'b0001 << col_idx_q);
    assign cmd       = cmd_q;
    assign cmd_valid = cmd_valid_q;

endmodule

// File: tb/tb_keypad_cmd_encoder.sv
// Directed bench for keypad_cmd_encoder with a behavioural 4x4 keypad matrix model.
module tb_keypad_cmd_encoder;

    logic       clock = 1'b0;
    logic       reset;
    logic [3:0] row;
    logic [3:0] col;
    logic [3:0] cmd;
    logic       cmd_valid;

    logic [3:0] pressed [4];
    bit         bounce_en  = 1'b0;
    bit         bounce_lvl = 1'b1;

    int checks = 0;
    int fails  = 0;

    always #5 clock = ~clock;

    keypad_cmd_encoder #(
        .SCAN_DIV     (4),
        .DEBOUNCE_CNT (3)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .row       (row),
        .col       (col),
        .cmd       (cmd),
        .cmd_valid (cmd_valid)
    );

    // A pressed switch at (r,c) pulls row r low while column c is driven low.
    always_comb begin
        row = 4'b1111;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (pressed[r][c] === 1'b1 && col[c] === 1'b0) row[r] = 1'b0;
        if (bounce_en && !bounce_lvl) row[3] = 1'b0;
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // Pulses must never be adjacent and must be at least 2*DEBOUNCE_CNT ticks (24 cycles) apart.
    bit prev_vld   = 1'b0;
    int cyc        = 0;
    int last_pulse = -1000;
    always @(negedge clock) begin
        cyc++;
        if (cmd_valid === 1'b1) begin
            check("no_back_to_back", {31'd0, prev_vld}, 32'd0);
            checks++;
            if (cyc - last_pulse < 24) begin
                fails++;
                $display("FAIL pulse_spacing: actual=%0d cycles required>=24", cyc - last_pulse);
            end
            last_pulse = cyc;
        end
        prev_vld = cmd_valid;
    end

    task automatic run_cycles(input int n, output int np, output logic [3:0] lc);
        np = 0;
        lc = 4'h0;
        for (int i = 0; i < n; i++) begin
            @(negedge clock);
            if (cmd_valid === 1'b1) begin
                np++;
                lc = cmd;
            end
        end
    endtask

    function automatic logic [3:0] col_pat(input int c);
        logic [3:0] p;
        p = 4'b1111;
        p[c] = 1'b0;
        return p;
    endfunction

    typedef struct {
        int         r;
        int         c;
        logic [3:0] exp;
    } key_vec_t;

    key_vec_t   vecs [20];
    int         np, np2;
    logic [3:0] lc, lc2;

    initial begin
        vecs[0]  = '{0, 0, 4'h1};
        vecs[1]  = '{0, 3, 4'hA};
        vecs[2]  = '{0, 0, 4'h1};
        vecs[3]  = '{0, 3, 4'hA};
        vecs[4]  = '{0, 0, 4'h1};
        vecs[5]  = '{3, 2, 4'hE};
        vecs[6]  = '{0, 2, 4'h3};
        vecs[7]  = '{1, 3, 4'hB};
        vecs[8]  = '{0, 1, 4'h2};
        vecs[9]  = '{3, 2, 4'hE};
        vecs[10] = '{1, 0, 4'h4};
        vecs[11] = '{1, 1, 4'h5};
        vecs[12] = '{1, 2, 4'h6};
        vecs[13] = '{2, 0, 4'h7};
        vecs[14] = '{2, 1, 4'h8};
        vecs[15] = '{2, 2, 4'h9};
        vecs[16] = '{2, 3, 4'hC};
        vecs[17] = '{3, 0, 4'hF};
        vecs[18] = '{3, 1, 4'h0};
        vecs[19] = '{3, 3, 4'hD};
        for (int r = 0; r < 4; r++) pressed[r] = 4'b0000;

        // Reset state
        reset = 1'b1;
        repeat (4) @(negedge clock);
        check("reset_col", {28'd0, col}, 32'hE);
        check("reset_cmd", {28'd0, cmd}, 32'h0);
        check("reset_cmd_valid", {31'd0, cmd_valid}, 32'd0);

        // Idle scan: first slot is 3 samples long because the counter starts at 0 on release.
        reset = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clock);
            check($sformatf("idle_col_%0d", k), {28'd0, col}, {28'd0, col_pat(((k + 1) / 4) % 4)});
            check($sformatf("idle_valid_%0d", k), {31'd0, cmd_valid}, 32'd0);
        end
        check("idle_cmd", {28'd0, cmd}, 32'h0);

        // Table-driven key presses
        for (int i = 0; i < 20; i++) begin
            pressed[vecs[i].r][vecs[i].c] = 1'b1;
            run_cycles(80, np, lc);
            check($sformatf("key%0d_pulses", i), np, 1);
            check($sformatf("key%0d_cmd", i), {28'd0, lc}, {28'd0, vecs[i].exp});
            check($sformatf("key%0d_col_frozen", i), {28'd0, col}, {28'd0, col_pat(vecs[i].c)});
            pressed[vecs[i].r][vecs[i].c] = 1'b0;
            run_cycles(40, np2, lc2);
            check($sformatf("key%0d_release_pulses", i), np2, 0);
            check($sformatf("key%0d_cmd_held", i), {28'd0, cmd}, {28'd0, vecs[i].exp});
        end

        // Contact bounce on row 3, then a clean press of r3/c2
        bounce_en = 1'b1;
        np2 = 0;
        for (int i = 0; i < 6; i++) begin
            bounce_lvl = ~bounce_lvl;
            run_cycles(5, np, lc);
            np2 += np;
        end
        check("bounce_pulses", np2, 0);
        bounce_en  = 1'b0;
        bounce_lvl = 1'b1;
        pressed[3][2] = 1'b1;
        run_cycles(80, np, lc);
        check("settle_pulses", np, 1);
        check("settle_cmd", {28'd0, lc}, 32'hE);
        pressed[3][2] = 1'b0;
        run_cycles(40, np, lc);
        check("settle_release_pulses", np, 0);

        // Long hold of r1/c1 with r2/c2 pressed mid-hold
        pressed[1][1] = 1'b1;
        run_cycles(40, np, lc);
        check("hold_first_pulses", np, 1);
        check("hold_cmd", {28'd0, lc}, 32'h5);
        pressed[2][2] = 1'b1;
        run_cycles(160, np2, lc2);
        check("hold_second_key_pulses", np2, 0);
        check("hold_col_frozen", {28'd0, col}, 32'hD);
        check("hold_cmd_kept", {28'd0, cmd}, 32'h5);
        pressed[1][1] = 1'b0;
        pressed[2][2] = 1'b0;
        run_cycles(40, np, lc);
        check("hold_release_pulses", np, 0);

        // Reset during DEB_PRESS of r3/c0, key still held afterwards
        reset = 1'b1;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        pressed[3][0] = 1'b1;
        run_cycles(6, np, lc);
        check("pre_reset_pulses", np, 0);
        reset = 1'b1;
        run_cycles(3, np, lc);
        check("in_reset_pulses", np, 0);
        check("in_reset_cmd", {28'd0, cmd}, 32'h0);
        check("in_reset_col", {28'd0, col}, 32'hE);
        reset = 1'b0;
        run_cycles(80, np, lc);
        check("post_reset_pulses", np, 1);
        check("post_reset_cmd", {28'd0, lc}, 32'hF);
        pressed[3][0] = 1'b0;
        run_cycles(40, np, lc);
        check("post_reset_release_pulses", np, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
